// File: rtl/mp_add_seq.sv
// rtl/mp_add_seq.sv - word-serial multi-precision add/subtract through a shared external 32-bit adder
module mp_add_seq #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  op_sub,
    input  logic [32*WORDS-1:0]   a,
    input  logic [32*WORDS-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [32*WORDS-1:0]   result,
    output logic                  carry_out,
    output logic                  overflow,
    output logic [31:0]           add_x,
    output logic [31:0]           add_y,
    output logic                  add_cin,
    input  logic [31:0]           add_sum,
    input  logic                  add_c32
);

    localparam int N     = 32 * WORDS;
    // One extra count of headroom so the post-increment index never wraps.
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             op_sub_q, op_sub_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     b_q, b_d;
    logic [N-1:0]     result_q, result_d;
    logic             carry_out_q, carry_out_d;
    logic             overflow_q, overflow_d;

    logic [31:0]      word_a;
    logic [31:0]      word_b;
    logic [31:0]      y_eff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            op_sub_q    <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            op_sub_q    <= op_sub_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

    always_comb begin
        word_a = '0;
        word_b = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (idx_q == IDX_W'(w)) begin
                word_a = a_q[w*32 +: 32];
                word_b = b_q[w*32 +: 32];
            end
        end
        // Subtraction is a + ~b + 1; the +1 enters via the carry seeded at start.
        y_eff = op_sub_q ? ~word_b : word_b;
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        op_sub_d    = op_sub_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        add_x       = '0;
        add_y       = '0;
        add_cin     = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    op_sub_d = op_sub;
                    idx_d    = '0;
                    carry_d  = op_sub;
                    state_d  = RUN;
                end
            end
            RUN: begin
                add_x   = word_a;
                add_y   = y_eff;
                add_cin = carry_q;
                for (int w = 0; w < WORDS; w++) begin
                    if (idx_q == IDX_W'(w)) begin
                        result_d[w*32 +: 32] = add_sum;
                    end
                end
                carry_d = add_c32;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(WORDS - 1)) begin
                    state_d     = DONE;
                    carry_out_d = add_c32;
                    overflow_d  = (word_a[31] == y_eff[31]) && (add_sum[31] != word_a[31]);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// tb/tb_mp_add_seq.sv - self-checking bench for mp_add_seq with an arithmetic reference model
module tb_mp_add_seq;

    localparam int WORDS = 4;
    localparam int N     = 32 * WORDS;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic           op_sub;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [N-1:0]   result;
    logic           carry_out;
    logic           overflow;
    logic [31:0]    add_x;
    logic [31:0]    add_y;
    logic           add_cin;
    logic [31:0]    add_sum;
    logic           add_c32;
    logic [32:0]    ext_sum;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Shared external adder is purely combinational.
    assign ext_sum = {1'b0, add_x} + {1'b0, add_y} + {32'b0, add_cin};
    assign add_sum = ext_sum[31:0];
    assign add_c32 = ext_sum[32];

    mp_add_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op_sub    (op_sub),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .add_x     (add_x),
        .add_y     (add_y),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_c32   (add_c32)
    );

    task automatic check(input string tag, input logic [N:0] obs, input logic [N:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: unsigned (N+1)-bit arithmetic for result/carry, signed (N+1)-bit for overflow.
    task automatic model(input logic [N-1:0] ma, input logic [N-1:0] mb, input logic sub,
                         output logic [N-1:0] r, output logic c, output logic v);
        logic [N:0]        u;
        logic signed [N:0] s;
        if (sub) begin
            u = {1'b0, ma} + {1'b0, ~mb} + (N+1)'(1);
            s = $signed({ma[N-1], ma}) - $signed({mb[N-1], mb});
        end else begin
            u = {1'b0, ma} + {1'b0, mb};
            s = $signed({ma[N-1], ma}) + $signed({mb[N-1], mb});
        end
        r = u[N-1:0];
        c = u[N];
        v = (s[N] != s[N-1]);
    endtask

    task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic sub,
                          input string tag);
        logic [N-1:0] er;
        logic         ec;
        logic         ev;
        logic [N-1:0] yb;
        model(ta, tb, sub, er, ec, ev);
        yb = sub ? ~tb : tb;
        @(negedge clk);
        a = ta; b = tb; op_sub = sub; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, ".busy0"}, busy, 1'b1);
        check({tag, ".x0"}, add_x, ta[31:0]);
        check({tag, ".y0"}, add_y, yb[31:0]);
        check({tag, ".cin0"}, add_cin, sub);
        repeat (WORDS - 1) @(negedge clk);
        check({tag, ".done_early"}, done, 1'b0);
        @(negedge clk);
        check({tag, ".done"}, done, 1'b1);
        check({tag, ".busy_done"}, busy, 1'b0);
        check({tag, ".result"}, result, er);
        check({tag, ".carry"}, carry_out, ec);
        check({tag, ".ovf"}, overflow, ev);
        @(negedge clk);
        check({tag, ".done_width"}, done, 1'b0);
        check({tag, ".hold"}, result, er);
    endtask

    initial begin
        logic [N-1:0] ones;
        logic [N-1:0] r1;
        logic [N-1:0] r2;
        logic         c1;
        logic         v1;
        logic         seen_done;
        ones   = '1;
        rst_n  = 1'b1;
        start  = 1'b0;
        op_sub = 1'b0;
        a      = '0;
        b      = '0;

        #1 rst_n = 1'b0;
        #2;
        check("rst.busy", busy, 1'b0);
        check("rst.done", done, 1'b0);
        check("rst.result", result, '0);
        check("rst.carry", carry_out, 1'b0);
        check("rst.ovf", overflow, 1'b0);
        check("rst.addx", add_x, '0);
        check("rst.addy", add_y, '0);
        check("rst.cin", add_cin, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(N'(1), N'(32'hFFFF_FFFE), 1'b0, "add_basic");
        run_op(N'(32'hFFFF_FFFF), N'(1), 1'b0, "add_wordcarry");
        run_op(ones, N'(1), 1'b0, "add_wrap");
        run_op({1'b0, ones[N-2:0]}, N'(1), 1'b0, "add_ovf");
        run_op(N'(5), N'(7), 1'b1, "sub_borrow");
        run_op(N'(7), N'(5), 1'b1, "sub_noborrow");
        run_op({1'b1, {(N-1){1'b0}}}, N'(1), 1'b1, "sub_ovf");

        for (int i = 0; i < 16; i++) begin
            run_op({$urandom, $urandom, $urandom, $urandom},
                   {$urandom, $urandom, $urandom, $urandom},
                   1'($urandom_range(0, 1)), "rand");
        end

        // start pulsed mid-RUN with different operands is ignored.
        model(N'(123456), N'(654321), 1'b0, r1, c1, v1);
        @(negedge clk);
        a = N'(123456); b = N'(654321); op_sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = ones; b = ones; op_sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("midstart.done", done, 1'b1);
        check("midstart.result", result, r1);

        // start held high through DONE: back-to-back with no idle cycle.
        model({4{32'h8000_0001}}, {4{32'h7FFF_FFFF}}, 1'b0, r1, c1, v1);
        model({4{32'h1234_5678}}, {4{32'h9ABC_DEF0}}, 1'b1, r2, c1, v1);
        @(negedge clk);
        a = {4{32'h8000_0001}}; b = {4{32'h7FFF_FFFF}}; op_sub = 1'b0; start = 1'b1;
        @(negedge clk);
        a = {4{32'h1234_5678}}; b = {4{32'h9ABC_DEF0}}; op_sub = 1'b1;
        repeat (WORDS) @(negedge clk);
        check("b2b.done1", done, 1'b1);
        check("b2b.result1", result, r1);
        @(negedge clk);
        start = 1'b0;
        check("b2b.done1_width", done, 1'b0);
        check("b2b.busy2", busy, 1'b1);
        repeat (WORDS - 1) @(negedge clk);
        check("b2b.done2_early", done, 1'b0);
        @(negedge clk);
        check("b2b.done2", done, 1'b1);
        check("b2b.result2", result, r2);
        check("b2b.carry2", carry_out, c1);
        @(negedge clk);
        check("b2b.done2_width", done, 1'b0);

        // Reset during RUN word 2 aborts with no done pulse.
        @(negedge clk);
        a = {4{32'hDEAD_BEEF}}; b = {4{32'h1111_1111}}; op_sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort.busy", busy, 1'b0);
        check("abort.done", done, 1'b0);
        check("abort.result", result, '0);
        check("abort.carry", carry_out, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (WORDS + 2) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check("abort.no_done", seen_done, 1'b0);
        run_op({$urandom, $urandom, $urandom, $urandom},
               {$urandom, $urandom, $urandom, $urandom}, 1'b1, "after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
